regfile_read_port: RTL

Read side of the integer register bank, whose cells are written on the falling edge of `clk`. The block accepts source-register read requests through a valid/ready handshake, drives the bank's combinational read addresses, and captures operands on the rising edge. Captured operands sit in a two-entry elastic buffer so downstream stalls never force the bank to be re-read. It sits between decode and execute.

---
 rtl/regfile_read_port.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/regfile_read_port.sv
// regfile_read_port: read side of the integer register bank.
// Accepts source-register read requests through valid/ready, drives the bank's
// combinational read addresses, captures operands on the rising edge and holds
// them in a two-entry elastic buffer (OUT + SKID). The buffer keeps downstream
// stalls from forcing a re-read of the bank.
//
// Optional feature: define READ_BYPASS_EN to have held operands track
// writebacks while they wait, so they never go stale during a stall.
module regfile_read_port #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    output logic [AW-1:0]   bank_raddr_a,
    output logic [AW-1:0]   bank_raddr_b,
    input  logic [XLEN-1:0] bank_rdata_a,
    input  logic [XLEN-1:0] bank_rdata_b,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2
);

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
    } entry_t;

    // Buffer occupancy, encoded as {SKID.valid, OUT.valid}.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    entry_t capture;
    entry_t out_held;
    entry_t skid_held;
    logic   accept;
    logic   pop;

`ifdef READ_BYPASS_EN
    // Replace any held operand whose source register is being written back now.
    function automatic entry_t apply_wb(input entry_t e, input logic we,
                                        input logic [AW-1:0] waddr,
                                        input logic [XLEN-1:0] wdata);
        entry_t r;
        r = e;
        if (e.valid && we && (waddr != '0)) begin
            if (e.rs1 == waddr) r.op1 = wdata;
            if (e.rs2 == waddr) r.op2 = wdata;
        end
        return r;
    endfunction
`else
    // Writeback is only consumed when the bypass is built in.
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_waddr, wb_wdata};
`endif

    // The bank reads combinationally straight from the request addresses.
    assign bank_raddr_a = in_rs1;
    assign bank_raddr_b = in_rs2;

    // in_ready comes from registered state only, never from out_ready.
    assign in_ready  = !skid_q.valid;
    assign out_valid = out_q.valid;
    assign out_rs1   = out_q.rs1;
    assign out_rs2   = out_q.rs2;
    assign out_op1   = out_q.op1;
    assign out_op2   = out_q.op2;

    assign accept = in_valid & in_ready;
    assign pop    = out_q.valid & out_ready;

    // Operand capture: register 0 always reads as zero regardless of the bank.
    always_comb begin
        capture.valid = 1'b1;
        capture.rs1   = in_rs1;
        capture.rs2   = in_rs2;
        capture.op1   = (in_rs1 == '0) ? '0 : bank_rdata_a;
        capture.op2   = (in_rs2 == '0) ? '0 : bank_rdata_b;
    end

    // Held entries as they would look after this edge if nothing overwrites them.
    always_comb begin
`ifdef READ_BYPASS_EN
        out_held  = apply_wb(out_q,  wb_we, wb_waddr, wb_wdata);
        skid_held = apply_wb(skid_q, wb_we, wb_waddr, wb_wdata);
`else
        out_held  = out_q;
        skid_held = skid_q;
`endif
    end

    // Next-state of the two-entry FIFO: OUT is always the oldest entry.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        out_d  = out_held;
        skid_d = skid_held;
        case ({skid_q.valid, out_q.valid})
            ST_EMPTY: begin
                if (accept) out_d = capture;
            end
            ST_ONE: begin
                if (accept && pop) begin
                    out_d = capture;
                end else if (accept) begin
                    skid_d = capture;
                end else if (pop) begin
                    out_d = '0;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    out_d  = skid_held;
                    skid_d = '0;
                end
            end
            default: begin
                out_d  = '0;
                skid_d = '0;
            end
        endcase
    end

    // Buffer registers; asynchronous reset discards everything held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            // NOTE: state updates are non-blocking so every flop samples pre-edge values.
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

endmodule
